adc_acq_sequencer: RTL and testbench
====================================

Name: adc_acq_sequencer

Overview:
Sequences ADC acquisitions for the DMA path. On a start command it issues cnv pulses at a programmed period and collects the samples returned by the ADC readout block. It packs those samples into AXI4-Stream frames of cfg_samples beats, with tlast on each frame end. It stops after cfg_frames frames, or runs until abort when continuous mode is set.

Parameters:
DATA_W, 32, sample/stream data width
CNV_CYCLES, 2, cnv high time in aclk cycles (>=1)
MIN_PERIOD, 16, floor applied to cfg_period
TIMEOUT_CYCLES, 1024, busy timeout (BUSY_TIMEOUT_EN only)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse
abort  in  1  one-cycle abort pulse
cfg_period  in  32  conversion period in aclk cycles
cfg_samples  in  16  beats per frame
cfg_frames  in  16  frames per run (ignored if cfg_continuous)
cfg_continuous  in  1  run until abort
busy  in  1  ADC busy, asynchronous to aclk
s_sample_data  in  DATA_W  sample from readout
s_sample_valid  in  1  one-cycle sample strobe, no backpressure
cnv  out  1  ADC convert-start
m_axis_tdata  out  DATA_W  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  frame end
running  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on return to IDLE
overrun  out  1  sticky: sample dropped (buffer full)
skipped  out  1  sticky: period tick lost to busy
frame_count  out  16  frames completed in current run

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; counters 0.
- Reset is asynchronous. Reset mid-run drops the buffered sample with no tlast.
- busy passes through a 2-FF synchronizer; busy_s is the synchronized value.
- Period: p = max(cfg_period, MIN_PERIOD). Config is latched on start; config changes while running have no effect.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN: on start with cfg_samples != 0 and (cfg_continuous or cfg_frames != 0).
  - start in any other case is ignored.
  - Entering RUN clears the sticky flags, the counters and frame_count.
- RUN period timer: counts 0..p-1 and wraps. The first tick is the cycle after entry.
- On each tick, if busy_s=0 and issued < total: cnv goes high for CNV_CYCLES cycles and issued increments.
  - total = cfg_samples*cfg_frames; it is unbounded if cfg_continuous.
  - If the tick finds busy_s=1, no cnv is issued and skipped is set.
- Output buffer: a 1-entry holding register.
  - When empty, s_sample_valid loads it.
  - When full and s_sample_valid arrives in the same cycle as the beat is accepted (tvalid&tready), the new sample loads; there is no loss.
  - Otherwise, when full, the new sample is dropped and overrun is set.
  - Sample counting is based on loaded samples, so dropped samples are never counted.
- tvalid is high while the buffer is full. tdata and tlast stay stable until the beat is accepted.
- tlast = 1 when the beat index within the frame == cfg_samples-1. Index wraps to 0 on acceptance.
- frame_count increments on each accepted tlast beat.
  - In continuous mode it wraps at 0xFFFF to 0.
- RUN -> DRAIN: when issued == total, or on abort.
  - abort halts cnv immediately; a cnv pulse already in progress completes its CNV_CYCLES.
- DRAIN -> IDLE: when the buffer is empty and busy_s=0.
  - On entering IDLE, done pulses for 1 cycle.
  - If an abort left a partial frame in the buffer, the final flushed beat carries forced tlast=1.
- Samples arriving in IDLE are dropped silently; the flags are not set.
- abort in IDLE is ignored. start while not in IDLE is ignored.
- start and abort in the same IDLE cycle: start is ignored.

Optional Feature:
ADC_ACQ_BUSY_TIMEOUT_EN
- Defined: after each cnv rising edge, a watchdog counts cycles.
  - If busy_s has not both risen and fallen within TIMEOUT_CYCLES, a sticky output timeout (1-bit, extra port) is set and the FSM enters DRAIN.
  - timeout clears when the FSM enters RUN.
- Undefined: no watchdog and no timeout port; a stuck busy holds DRAIN indefinitely.

Test Plan:
1. cfg_period=20, cfg_samples=4, cfg_frames=2, readout returns a sample 10 cycles after cnv, tready=1 -> cnv every 20 cycles, 8 beats, tlast on beats 4 and 8, frame_count=2, done pulses once, overrun=skipped=0.
2. cfg_period=3 -> effective period 16 (MIN_PERIOD); cnv rising edges 16 cycles apart.
3. Same as test 1 with tready=0 for 40 cycles -> first beat held stable, second sample dropped, overrun=1, no data corruption after tready returns.
4. busy forced high across a tick -> no cnv that period, skipped=1, next tick issues cnv normally.
5. cfg_continuous=1, cfg_samples=3, abort after 5 samples loaded -> beats 1-3 (tlast on 3), 4, 5 with forced tlast on 5, then done, running=0.
6. Assert aresetn mid-frame with tvalid=1 -> tvalid, cnv, running go 0 asynchronously; the next start begins with frame_count=0 and beat index 0.

Source files
------------

// File: rtl/adc_acq_sequencer.sv
// rtl/adc_acq_sequencer.sv - ADC conversion sequencer packing samples into AXI4-Stream frames
// Optional busy watchdog with extra timeout port: define ADC_ACQ_BUSY_TIMEOUT_EN.
module adc_acq_sequencer #(
  parameter int DATA_W         = 32,
  parameter int CNV_CYCLES     = 2,
  parameter int MIN_PERIOD     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cfg_period,
  input  logic [15:0]       cfg_samples,
  input  logic [15:0]       cfg_frames,
  input  logic              cfg_continuous,
  input  logic              busy,
  input  logic [DATA_W-1:0] s_sample_data,
  input  logic              s_sample_valid,
  output logic              cnv,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              running,
  output logic              done,
  output logic              overrun,
  output logic              skipped,
`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
  output logic              timeout,
`endif
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic        busy_meta, busy_s;
  logic [31:0] period_q, total_q, issued, tmr;
  logic [15:0] samples_q, idx, cnv_cnt;
  logic        cont_q, aborted_q;
  logic [1:0]  cnv_hist;
  logic        accept, tick, more, issue, quiet, cfg_ok, load, busy_clear;
  logic [31:0] eff_period;

  assign accept     = m_axis_tvalid & m_axis_tready;
  assign tick       = (state == RUN) && (tmr == 32'd0);
  assign more       = cont_q || (issued < total_q);
  assign issue      = tick && !busy_s && more && !abort;
  // cnv plus two cycles of history covers the busy synchronizer latency
  assign quiet      = !cnv && (cnv_hist == 2'b00);
  assign load       = (state != IDLE) && s_sample_valid && (!m_axis_tvalid || accept);
  assign cfg_ok     = (cfg_samples != 16'd0) && (cfg_continuous || (cfg_frames != 16'd0));
  assign eff_period = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;
  assign running    = (state != IDLE);

`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
  logic        wd_on, wd_rose;
  logic [31:0] wd_cnt;
  assign busy_clear = !busy_s || timeout;
`else
  assign busy_clear = !busy_s;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      busy_meta     <= 1'b0;
      busy_s        <= 1'b0;
      period_q      <= 32'd0;
      total_q       <= 32'd0;
      issued        <= 32'd0;
      tmr           <= 32'd0;
      samples_q     <= 16'd0;
      idx           <= 16'd0;
      cnv_cnt       <= 16'd0;
      cont_q        <= 1'b0;
      aborted_q     <= 1'b0;
      cnv_hist      <= 2'b00;
      cnv           <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      skipped       <= 1'b0;
      frame_count   <= 16'd0;
`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
      timeout       <= 1'b0;
      wd_on         <= 1'b0;
      wd_rose       <= 1'b0;
      wd_cnt        <= 32'd0;
`endif
    end else begin
      busy_meta <= busy;
      busy_s    <= busy_meta;
      done      <= 1'b0;
      cnv_hist  <= {cnv_hist[0], cnv};

      if (cnv) begin
        if (cnv_cnt == 16'd0) cnv <= 1'b0;
        else                  cnv_cnt <= cnv_cnt - 16'd1;
      end

      case (state)
        IDLE: begin
          if (start && !abort && cfg_ok) begin
            state       <= RUN;
            period_q    <= eff_period;
            samples_q   <= cfg_samples;
            cont_q      <= cfg_continuous;
            total_q     <= 32'(cfg_samples) * 32'(cfg_frames);
            issued      <= 32'd0;
            tmr         <= 32'd0;
            idx         <= 16'd0;
            frame_count <= 16'd0;
            overrun     <= 1'b0;
            skipped     <= 1'b0;
            aborted_q   <= 1'b0;
`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
            timeout     <= 1'b0;
            wd_on       <= 1'b0;
`endif
          end
        end
        RUN: begin
          tmr <= (tmr == period_q - 32'd1) ? 32'd0 : tmr + 32'd1;
          if (issue) begin
            cnv     <= 1'b1;
            cnv_cnt <= 16'(CNV_CYCLES - 1);
            issued  <= issued + 32'd1;
          end
          if (tick && busy_s && more && !abort) skipped <= 1'b1;
          if (abort) begin
            aborted_q <= 1'b1;
            state     <= DRAIN;
          end else if (!more) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!m_axis_tvalid && quiet && busy_clear) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        m_axis_tdata  <= s_sample_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (idx == samples_q - 16'd1);
        idx           <= (idx == samples_q - 16'd1) ? 16'd0 : idx + 16'd1;
      end else if (accept) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end else if (state == DRAIN && aborted_q && m_axis_tvalid && quiet && !busy_s) begin
        // no conversion left in flight: the held beat closes the aborted frame
        m_axis_tlast <= 1'b1;
      end

      if (accept && m_axis_tlast) frame_count <= frame_count + 16'd1;
      if (state != IDLE && s_sample_valid && m_axis_tvalid && !accept) overrun <= 1'b1;

`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
      if (issue) begin
        wd_on   <= 1'b1;
        wd_rose <= 1'b0;
        wd_cnt  <= 32'd0;
      end else if (wd_on && state != IDLE) begin
        if (busy_s) wd_rose <= 1'b1;
        if (wd_rose && !busy_s) begin
          wd_on <= 1'b0;
        end else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          wd_on   <= 1'b0;
          timeout <= 1'b1;
          if (state == RUN) state <= DRAIN;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb/tb_adc_acq_sequencer.sv - self-checking bench for adc_acq_sequencer
// Scoreboard model of the sample buffer and framing, with directed scenarios.
module tb_adc_acq_sequencer;

  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   cfg_period = 32'd20;
  logic [15:0]   cfg_samples = 16'd4;
  logic [15:0]   cfg_frames = 16'd2;
  logic          cfg_continuous = 1'b0;
  logic          adc_busy = 1'b0;
  logic          busy_force = 1'b0;
  logic          busy;
  logic [DW-1:0] s_sample_data = '0;
  logic          s_sample_valid = 1'b0;
  logic          cnv;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          running, done, overrun, skipped;
  logic [15:0]   frame_count;
`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
  logic          timeout;
`endif

  assign busy = adc_busy | busy_force;

  adc_acq_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_period(cfg_period), .cfg_samples(cfg_samples), .cfg_frames(cfg_frames),
    .cfg_continuous(cfg_continuous), .busy(busy),
    .s_sample_data(s_sample_data), .s_sample_valid(s_sample_valid),
    .cnv(cnv), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .running(running), .done(done), .overrun(overrun), .skipped(skipped),
`ifdef ADC_ACQ_BUSY_TIMEOUT_EN
    .timeout(timeout),
`endif
    .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       q[$];
  int          rises[$];
  int          tl[$];
  logic [31:0] acc_data[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          beats = 0;
  int          pushes = 0;
  logic        cnv_prev = 1'b0;
  logic        m_active = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_fc = 16'd0;
  logic [15:0] m_idx = 16'd0;
  logic [15:0] m_samples = 16'd0;

  // ADC: busy while converting, sample about 10 cycles after each cnv rising edge
  initial begin : adc
    int cd;
    logic seen;
    int n;
    cd = 0; seen = 1'b0; n = 0;
    forever begin
      @(posedge aclk); #1;
      s_sample_valid = 1'b0;
      if (!aresetn) begin
        cd = 0; adc_busy = 1'b0; seen = 1'b0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            n++;
            s_sample_valid = 1'b1;
            s_sample_data  = 32'hA500_0000 + n;
            adc_busy       = 1'b0;
          end
        end
        if (cnv && !seen) begin
          cd = 10;
          adc_busy = 1'b1;
        end
        seen = cnv;
      end
    end
  end

  // Compare outputs against the model, then advance the model to the next edge
  always @(negedge aclk) begin
    logic acc;
    beat_t b;
    cyc++;
    if (cnv && !cnv_prev) rises.push_back(cyc);
    cnv_prev = cnv;
    if (done) done_cnt++;
    if (!aresetn) begin
      q.delete();
      m_active = 1'b0; m_ovr = 1'b0; m_fc = 16'd0; m_idx = 16'd0;
    end else begin
      chk("tvalid", m_axis_tvalid, q.size() != 0);
      if (q.size() != 0 && m_axis_tvalid) chk("tdata", m_axis_tdata, q[0].data);
      chk("frame_count", frame_count, m_fc);
      chk("overrun", overrun, m_ovr);
      acc = (q.size() != 0) && m_axis_tready;
      if (acc) begin
        chk("tlast", m_axis_tlast, q[0].last);
        beats++;
        acc_data.push_back(q[0].data);
        if (q[0].last) begin
          m_fc++;
          tl.push_back(beats);
        end
        void'(q.pop_front());
      end
      if (s_sample_valid && m_active) begin
        if (q.size() == 0) begin
          b.data = s_sample_data;
          b.last = (m_idx == m_samples - 16'd1);
          m_idx  = b.last ? 16'd0 : m_idx + 16'd1;
          q.push_back(b);
          pushes++;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (done) m_active = 1'b0;
      if (abort && m_active && q.size() != 0) begin
        b = q.pop_back();
        b.last = 1'b1;
        q.push_back(b);
      end
      if (start && !abort && !m_active && cfg_samples != 0 && (cfg_continuous || cfg_frames != 0)) begin
        m_active = 1'b1; m_ovr = 1'b0; m_fc = 16'd0; m_idx = 16'd0;
        m_samples = cfg_samples;
        beats = 0; pushes = 0;
        tl.delete(); acc_data.delete();
      end
    end
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic pulse_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (running !== 1'b0 && k < limit) begin
      step();
      k++;
    end
    chk("wait_idle_running", running, 1'b0);
    step(); step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0, d0, k;

    repeat (3) @(posedge aclk);
    #2;
    chk("rst_cnv", cnv, 1'b0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_skipped", skipped, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    step(); aresetn = 1'b1;
    step(); step();

    // rejected starts and idle abort
    cfg_samples = 16'd0; pulse_start(); step();
    chk("start_zero_samples", running, 1'b0);
    cfg_samples = 16'd4; cfg_frames = 16'd0; pulse_start(); step();
    chk("start_zero_frames", running, 1'b0);
    cfg_frames = 16'd2;
    step(); start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0; step();
    chk("start_with_abort", running, 1'b0);
    step(); abort = 1'b1; step(); abort = 1'b0; step();
    chk("abort_in_idle", running, 1'b0);

    // test 1: nominal two frames, a stray start mid-run
    r0 = rises.size(); d0 = done_cnt;
    cfg_period = 32'd20; cfg_samples = 16'd4; cfg_frames = 16'd2; m_axis_tready = 1'b1;
    pulse_start();
    repeat (50) step();
    cfg_period = 32'd50; pulse_start(); cfg_period = 32'd20;
    wait_idle(600);
    chk("t1_cnv_count", rises.size() - r0, 8);
    if (rises.size() - r0 >= 8) begin
      chk("t1_cnv_gap_first", rises[r0+1] - rises[r0], 20);
      chk("t1_cnv_gap_last", rises[r0+7] - rises[r0+6], 20);
    end
    chk("t1_beats", beats, 8);
    chk("t1_tlast_count", tl.size(), 2);
    if (tl.size() == 2) begin
      chk("t1_tlast_pos0", tl[0], 4);
      chk("t1_tlast_pos1", tl[1], 8);
    end
    chk("t1_frame_count", frame_count, 16'd2);
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_overrun", overrun, 1'b0);
    chk("t1_skipped", skipped, 1'b0);

    // test 2: period floor
    r0 = rises.size();
    cfg_period = 32'd3; cfg_samples = 16'd2; cfg_frames = 16'd1;
    pulse_start();
    wait_idle(300);
    chk("t2_cnv_count", rises.size() - r0, 2);
    if (rises.size() - r0 >= 2) chk("t2_cnv_gap", rises[r0+1] - rises[r0], 16);
    chk("t2_beats", beats, 2);

    // test 3: stalled sink drops the second sample
    cfg_period = 32'd20; cfg_samples = 16'd4; cfg_frames = 16'd2;
    m_axis_tready = 1'b0;
    pulse_start();
    repeat (40) step();
    m_axis_tready = 1'b1;
    wait_idle(600);
    chk("t3_overrun", overrun, 1'b1);
    chk("t3_beats", beats, 7);
    chk("t3_frame_count", frame_count, 16'd1);
    chk("t3_tlast_count", tl.size(), 1);
    if (tl.size() == 1) chk("t3_tlast_pos", tl[0], 4);
    if (acc_data.size() >= 2) chk("t3_data_gap", acc_data[1] - acc_data[0], 2);

    // test 4: busy held across a tick
    r0 = rises.size();
    cfg_samples = 16'd4; cfg_frames = 16'd1;
    pulse_start();
    k = 0;
    while (rises.size() == r0 && k < 100) begin step(); k++; end
    chk("t4_first_cnv_seen", rises.size() - r0, 1);
    repeat (15) step();
    busy_force = 1'b1;
    repeat (10) step();
    busy_force = 1'b0;
    wait_idle(600);
    chk("t4_skipped", skipped, 1'b1);
    chk("t4_cnv_count", rises.size() - r0, 4);
    if (rises.size() - r0 >= 3) begin
      chk("t4_gap_skip", rises[r0+1] - rises[r0], 40);
      chk("t4_gap_next", rises[r0+2] - rises[r0+1], 20);
    end
    chk("t4_beats", beats, 4);

    // test 5: continuous run aborted with a partial frame held
    d0 = done_cnt;
    cfg_continuous = 1'b1; cfg_samples = 16'd3; cfg_frames = 16'd0;
    pulse_start();
    k = 0;
    while (beats < 4 && k < 400) begin step(); k++; end
    m_axis_tready = 1'b0;
    k = 0;
    while (pushes < 5 && k < 100) begin step(); k++; end
    chk("t5_pushes", pushes, 5);
    abort = 1'b1; step(); abort = 1'b0;
    repeat (8) step();
    m_axis_tready = 1'b1;
    wait_idle(200);
    cfg_continuous = 1'b0;
    chk("t5_beats", beats, 5);
    chk("t5_tlast_count", tl.size(), 2);
    if (tl.size() == 2) begin
      chk("t5_tlast_pos0", tl[0], 3);
      chk("t5_tlast_pos1", tl[1], 5);
    end
    chk("t5_frame_count", frame_count, 16'd2);
    chk("t5_done_once", done_cnt - d0, 1);
    chk("t5_running", running, 1'b0);

    // test 6: asynchronous reset while a beat is held
    cfg_samples = 16'd4; cfg_frames = 16'd2; m_axis_tready = 1'b0;
    pulse_start();
    k = 0;
    while (m_axis_tvalid !== 1'b1 && k < 100) begin step(); k++; end
    chk("t6_tvalid_before", m_axis_tvalid, 1'b1);
    aresetn = 1'b0;
    #2;
    chk("t6_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("t6_rst_cnv", cnv, 1'b0);
    chk("t6_rst_running", running, 1'b0);
    chk("t6_rst_frame_count", frame_count, 16'd0);
    repeat (3) step();
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    cfg_samples = 16'd2; cfg_frames = 16'd1;
    step();
    pulse_start();
    chk("t6_restart_running", running, 1'b1);
    chk("t6_restart_frame_count", frame_count, 16'd0);
    wait_idle(300);
    chk("t6_beats", beats, 2);
    chk("t6_tlast_count", tl.size(), 1);
    if (tl.size() == 1) chk("t6_tlast_pos", tl[0], 2);
    chk("t6_frame_count", frame_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
